// File: rtl/filt_win3_f16_if.sv
// Stream bus for the 3-tap window generator: sample input side and window output side.
// Latency: none (wires only).
// Backpressure: in_ready throttles the sample source; the window side has no backpressure.
interface filt_win3_f16_if;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_sol;
  logic        in_ready;
  logic [15:0] win_a;
  logic [15:0] win_b;
  logic [15:0] win_c;
  logic        win_valid;
  logic        win_last;

  // Sample source plus window consumer (testbench / upstream side)
  modport master (
    output in_valid, in_data, in_sol,
    input  in_ready, win_a, win_b, win_c, win_valid, win_last
  );

  // Window generator side
  modport slave (
    input  in_valid, in_data, in_sol,
    output in_ready, win_a, win_b, win_c, win_valid, win_last
  );
endinterface

// File: rtl/filt_win3_f16.sv
// Horizontal 3-tap centre-aligned window generator for float16 lines, edges padded.
// Latency: window k registered the cycle after x[k+1] is accepted; last window one cycle after FLUSH.
// Backpressure: in_ready drops for one FLUSH cycle per line; no downstream backpressure.
// Build option: define FILT_WIN3_ZERO_PAD_EN for zero edge taps instead of edge replication.
module filt_win3_f16 #(
  parameter int unsigned LINE_LEN = 640,
  parameter int unsigned CNT_W    = 16
) (
  input logic            clk,
  input logic            rst_n,
  filt_win3_f16_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_RUN   = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // smp_cur holds the most recently accepted sample, smp_prv the one before it
  logic [15:0]      smp_cur_q, smp_cur_d;
  logic [15:0]      smp_prv_q, smp_prv_d;
  logic [15:0]      win_a_q, win_a_d;
  logic [15:0]      win_b_q, win_b_d;
  logic [15:0]      win_c_q, win_c_d;
  logic             win_valid_q, win_valid_d;
  logic             win_last_q, win_last_d;

  logic             xfer;
  logic [15:0]      pad_left;
  logic [15:0]      pad_right;

  assign bus.in_ready = (state_q != S_FLUSH);
  assign xfer         = bus.in_valid && bus.in_ready;

  // Edge taps: in FILL smp_cur is x0, in FLUSH smp_cur is x(N-1)
`ifdef FILT_WIN3_ZERO_PAD_EN
  assign pad_left  = 16'h0000;
  assign pad_right = 16'h0000;
`else
  assign pad_left  = smp_cur_q;
  assign pad_right = smp_cur_q;
`endif

  // Next-state and window assembly; window registers hold between pulses
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    smp_cur_d   = smp_cur_q;
    smp_prv_d   = smp_prv_q;
    win_a_d     = win_a_q;
    win_b_d     = win_b_q;
    win_c_d     = win_c_q;
    win_valid_d = 1'b0;
    win_last_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // in_sol is irrelevant here: any accepted sample is x0
        if (xfer) begin
          smp_cur_d = bus.in_data;
          cnt_d     = CNT_ONE;
          state_d   = S_FILL;
        end
      end

      S_FILL, S_RUN: begin
        if (xfer) begin
          if (bus.in_sol) begin
            // Resync: drop the partial line, this sample is the new x0
            smp_cur_d = bus.in_data;
            cnt_d     = CNT_ONE;
            state_d   = S_FILL;
          end else begin
            win_a_d     = (state_q == S_FILL) ? pad_left : smp_prv_q;
            win_b_d     = smp_cur_q;
            win_c_d     = bus.in_data;
            win_valid_d = 1'b1;
            smp_prv_d   = smp_cur_q;
            smp_cur_d   = bus.in_data;
            cnt_d       = cnt_q + CNT_ONE;
            state_d     = (cnt_q == LAST_IDX) ? S_FLUSH : S_RUN;
          end
        end
      end

      S_FLUSH: begin
        // Final window needs no new sample; input is held off for this cycle
        win_a_d     = smp_prv_q;
        win_b_d     = smp_cur_q;
        win_c_d     = pad_right;
        win_valid_d = 1'b1;
        win_last_d  = 1'b1;
        cnt_d       = '0;
        state_d     = S_IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State, sample history and window registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      smp_cur_q   <= 16'h0000;
      smp_prv_q   <= 16'h0000;
      win_a_q     <= 16'h0000;
      win_b_q     <= 16'h0000;
      win_c_q     <= 16'h0000;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      smp_cur_q   <= smp_cur_d;
      smp_prv_q   <= smp_prv_d;
      win_a_q     <= win_a_d;
      win_b_q     <= win_b_d;
      win_c_q     <= win_c_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
    end
  end

  assign bus.win_a     = win_a_q;
  assign bus.win_b     = win_b_q;
  assign bus.win_c     = win_c_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;

endmodule

// File: tb/tb_filt_win3_f16.sv
// Bench for filt_win3_f16: one 4-sample-line and one 2-sample-line instance.
// Stimulus drives samples; a line-level model queues expected windows; a monitor compares.
// Honours FILT_WIN3_ZERO_PAD_EN in the model so either build can be checked.
module tb_filt_win3_f16;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic        last;
  } win_t;

  logic clk;
  logic rst_n;

  filt_win3_f16_if if4 ();
  filt_win3_f16_if if2 ();

  filt_win3_f16 #(.LINE_LEN(4), .CNT_W(16)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  filt_win3_f16 #(.LINE_LEN(2), .CNT_W(16)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  int n_tests = 0;
  int n_fail  = 0;
  int pulses4 = 0;
  int pulses2 = 0;
  int lowrdy4 = 0;

  win_t        exp4[$];
  win_t        exp2[$];
  logic [15:0] line4[$];
  logic [15:0] line2[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 500000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  function automatic logic [15:0] pad(input logic [15:0] edge_smp);
`ifdef FILT_WIN3_ZERO_PAD_EN
    return 16'h0000;
`else
    return edge_smp;
`endif
  endfunction

  // Window k of a line of n samples, directly from the definition
  function automatic win_t mk(input int k, input logic [15:0] ln[$], input int n);
    win_t w;
    w.a    = (k == 0)     ? pad(ln[0])     : ln[k-1];
    w.b    = ln[k];
    w.c    = (k == n - 1) ? pad(ln[n - 1]) : ln[k+1];
    w.last = (k == n - 1);
    return w;
  endfunction

  // Model: window k becomes due once x[k+1] exists; the last once the line is complete
  task automatic model_accept(input int which, input logic [15:0] d, input logic sol);
    logic [15:0] ln[$];
    int n;
    if (which == 4) begin ln = line4; n = 4; end
    else begin ln = line2; n = 2; end
    if (ln.size() > 0 && sol) ln.delete();
    ln.push_back(d);
    if (ln.size() >= 2) begin
      if (which == 4) exp4.push_back(mk(ln.size() - 2, ln, n));
      else exp2.push_back(mk(ln.size() - 2, ln, n));
    end
    if (ln.size() == n) begin
      if (which == 4) exp4.push_back(mk(n - 1, ln, n));
      else exp2.push_back(mk(n - 1, ln, n));
      ln.delete();
    end
    if (which == 4) line4 = ln;
    else line2 = ln;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge
  task automatic send(input int which, input logic [15:0] d, input logic sol);
    int  tries = 0;
    bit  done  = 0;
    logic rdy;
    if (which == 4) begin if4.in_valid = 1'b1; if4.in_data = d; if4.in_sol = sol; end
    else begin if2.in_valid = 1'b1; if2.in_data = d; if2.in_sol = sol; end
    while (!done) begin
      rdy = (which == 4) ? if4.in_ready : if2.in_ready;
      @(posedge clk);
      if (rdy) begin
        model_accept(which, d, sol);
        done = 1;
      end
      #1;
      tries++;
      if (!done && tries > 10) begin
        n_tests++;
        n_fail++;
        $display("FAIL accept_timeout: in_ready low for %0d cycles, required <= 10", tries);
        done = 1;
      end
    end
    if (which == 4) begin if4.in_valid = 1'b0; if4.in_sol = 1'b0; end
    else begin if2.in_valid = 1'b0; if2.in_sol = 1'b0; end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp4.size() != 0 || exp2.size() != 0) && t < 20) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_exp4", exp4.size(), 0);
    chk("drain_exp2", exp2.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_a4"}, if4.win_a, 16'h0000);
    chk({tag, "_b4"}, if4.win_b, 16'h0000);
    chk({tag, "_c4"}, if4.win_c, 16'h0000);
    chk({tag, "_vld4"}, if4.win_valid, 0);
    chk({tag, "_last4"}, if4.win_last, 0);
    chk({tag, "_rdy4"}, if4.in_ready, 1);
    chk({tag, "_vld2"}, if2.win_valid, 0);
    chk({tag, "_rdy2"}, if2.in_ready, 1);
  endtask

  task automatic mon_cmp(input string nm, input win_t got, input win_t want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got a=%h b=%h c=%h last=%b, expected a=%h b=%h c=%h last=%b",
               nm, got.a, got.b, got.c, got.last, want.a, want.b, want.c, want.last);
    end
  endtask

  // Monitor: every window pulse must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (!if4.in_ready) lowrdy4++;
      if (if4.win_valid) begin
        pulses4++;
        if (exp4.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL win4_unexpected: pulse with a=%h b=%h c=%h, expected no pulse",
                   if4.win_a, if4.win_b, if4.win_c);
        end else begin
          mon_cmp("win4", {if4.win_a, if4.win_b, if4.win_c, if4.win_last}, exp4.pop_front());
        end
      end else begin
        chk("win4_last_idle", if4.win_last, 0);
      end
      if (if2.win_valid) begin
        pulses2++;
        if (exp2.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL win2_unexpected: pulse with a=%h b=%h c=%h, expected no pulse",
                   if2.win_a, if2.win_b, if2.win_c);
        end else begin
          mon_cmp("win2", {if2.win_a, if2.win_b, if2.win_c, if2.win_last}, exp2.pop_front());
        end
      end else begin
        chk("win2_last_idle", if2.win_last, 0);
      end
    end
  end

  initial begin
    logic [15:0] seq4 [4];
    int p0;
    seq4[0] = 16'h3C00; seq4[1] = 16'h4000; seq4[2] = 16'h4200; seq4[3] = 16'h4400;
    rst_n = 1'b0;
    if4.in_valid = 1'b0; if4.in_data = 16'h0; if4.in_sol = 1'b0;
    if2.in_valid = 1'b0; if2.in_data = 16'h0; if2.in_sol = 1'b0;
    #12;
    chk_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);

    // Back-to-back 4-sample line: one in_ready bubble, four pulses
    lowrdy4 = 0;
    p0 = pulses4;
    for (int i = 0; i < 4; i++) send(4, seq4[i], 1'b0);
    idle(4);
    chk("b2b_rdy_bubble", lowrdy4, 1);
    chk("b2b_pulses", pulses4 - p0, 4);

    // Same line with random input gaps
    p0 = pulses4;
    for (int i = 0; i < 4; i++) begin
      idle($urandom_range(0, 3));
      send(4, seq4[i], 1'b0);
    end
    idle(4);
    chk("gap_pulses", pulses4 - p0, 4);

    // Mid-line resync with in_sol
    send(4, 16'h3C00, 1'b0);
    send(4, 16'h4000, 1'b0);
    send(4, 16'h4800, 1'b1);
    send(4, 16'h4A00, 1'b0);
    send(4, 16'h4C00, 1'b0);
    send(4, 16'h4D00, 1'b0);
    drain();

    // Reset in RUN after 3 samples, then a fresh line
    send(4, 16'h3C00, 1'b0);
    send(4, 16'h4000, 1'b0);
    send(4, 16'h4200, 1'b0);
    idle(3);
    rst_n = 1'b0;
    line4.delete();
    #1;
    chk_reset_outputs("midreset");
    chk("midreset_pending", exp4.size(), 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 4; i++) send(4, seq4[3 - i], 1'b0);
    drain();

    // Two-sample line
    send(2, 16'h3C00, 1'b0);
    send(2, 16'h4000, 1'b0);
    drain();
    chk("n2_pulses", pulses2, 2);

    // Random lines with gaps and occasional resync on both instances
    for (int l = 0; l < 40; l++) begin
      int which;
      which = ($urandom_range(0, 1) == 0) ? 4 : 2;
      for (int s = 0; s < $urandom_range(1, 6); s++) begin
        idle($urandom_range(0, 2));
        send(which, 16'($urandom), ($urandom_range(0, 9) == 0));
      end
    end
    idle(4);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
